dm_lsu: RTL and testbench

Parametrised data-memory load/store unit, the next generation of the byte-enabled 4K data memory. It accepts one request at a time over a valid/ready handshake and derives byte enables internally from address and size. It returns sign- or zero-extended load data, flags misaligned or out-of-range accesses, and can emulate slower memory through a configurable wait count. It sits between the MEM pipeline stage and on-chip storage.

---
 rtl/dm_pkg.sv | 22 ++
 rtl/dm_lane_align.sv | 86 ++++++++
 rtl/dm_lsu.sv | 229 ++++++++++++++++++++++
 tb/tb_dm_lsu.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the dm_lsu data-memory load/store unit.
//   - request size encodings (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_BAD)
//   - FSM state encoding for the access sequencer
//   - WAIT_W: width of the wait-cycle down-counter
package dm_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: combinational little-endian lane steering for dm_lsu.
// Ports:
//   addr_i[1:0]  byte offset within the 32-bit word
//   size_i[1:0]  access size (dm_pkg::size_e encoding)
//   unsigned_i   zero-extend (1) / sign-extend (0) sub-word loads
//   wdata_i      right-justified store data
//   raw_i        word currently held in storage
//   be_o         per-lane byte enables for a store
//   wdata_o      store data replicated onto the addressed lanes
//   rdata_o      selected byte/half right-justified and extended
module dm_lane_align (
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] raw_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    import dm_pkg::*;

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection, enable generation and load extension.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
        rdata_o = 32'h0000_0000;
        byte_s  = 8'h00;
        half_s  = 16'h0000;

        case (addr_i)
            2'b00:   byte_s = raw_i[7:0];
            2'b01:   byte_s = raw_i[15:8];
            2'b10:   byte_s = raw_i[23:16];
            2'b11:   byte_s = raw_i[31:24];
            default: byte_s = 8'h00;
        endcase

        // Half alignment is enforced upstream, so only addr[1] picks the half.
        if (addr_i[1]) begin
            half_s = raw_i[31:16];
        end else begin
            half_s = raw_i[15:0];
        end

        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_i;
                // Replicating the byte puts it on every lane; be_o picks the one written.
                wdata_o = {4{wdata_i[7:0]}};
                if (unsigned_i) begin
                    rdata_o = {24'h00_0000, byte_s};
                end else begin
                    rdata_o = {{24{byte_s[7]}}, byte_s};
                end
            end
            SZ_HALF: begin
                if (addr_i[1]) begin
                    be_o = 4'b1100;
                end else begin
                    be_o = 4'b0011;
                end
                wdata_o = {2{wdata_i[15:0]}};
                if (unsigned_i) begin
                    rdata_o = {16'h0000, half_s};
                end else begin
                    rdata_o = {{16{half_s[15]}}, half_s};
                end
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = raw_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0000_0000;
                rdata_o = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/dm_lsu.sv
// dm_lsu: byte-enabled data-memory load/store unit with valid/ready request
// handshake, one outstanding request, optional emulated wait states.
// Ports:
//   clk, rst_n      rising-edge clock, async active-low reset
//   req_valid/ready request handshake; ready is high only in IDLE
//   req_we          1 = store, 0 = load
//   req_addr        byte address (ADDR_W+2 bits)
//   req_size        00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned    zero-extend sub-word loads when 1
//   req_wdata       right-justified store data
//   rsp_valid       one-cycle response strobe
//   rsp_rdata       extended load data (0 for stores and faults)
//   rsp_fault       access rejected (misaligned, bad size, out of range)
module dm_lsu #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 3072,
    parameter int WAIT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault
);
    import dm_pkg::*;

    localparam int                BA_W      = ADDR_W + 2;
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic              WAIT_EN   = (WAIT > 0) ? 1'b1 : 1'b0;
    localparam logic [WAIT_W-1:0] WAIT_INIT = (WAIT > 0) ? WAIT_W'(WAIT - 1) : {WAIT_W{1'b0}};

    // Size/alignment/range check applied to the request at accept time.
    function automatic logic access_fault(input logic [1:0]        size,
                                          input logic [1:0]        off,
                                          input logic [ADDR_W-1:0] idx);
        logic f;
        case (size)
            SZ_BYTE: f = 1'b0;
            SZ_HALF: f = off[0];
            SZ_WORD: f = (off != 2'b00);
            default: f = 1'b1;
        endcase
        return f | ({1'b0, idx} >= DEPTH_L);
    endfunction

    // Storage: not reset, contents survive rst_n.
    logic [31:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [BA_W-1:0]   addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_fault_q, rsp_fault_d;

    logic              accept_s;
    logic              req_fault_s;
    logic              commit_s;
    logic [BA_W-1:0]   acc_addr_s;
    logic [1:0]        acc_size_s;
    logic              acc_we_s;
    logic              acc_uns_s;
    logic [31:0]       acc_wdata_s;
    logic [ADDR_W-1:0] acc_idx_s;
    logic [31:0]       raw_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_lane_s;
    logic [31:0]       load_data_s;

    assign req_ready   = (state_q == ST_IDLE);
    assign accept_s    = req_valid & req_ready;
    assign req_fault_s = access_fault(req_size, req_addr[1:0], req_addr[BA_W-1:2]);

    // With WAIT==0 the access commits on the accept edge itself, so in IDLE
    // the live request drives the datapath; otherwise the latched copy does.
    always_comb begin
        acc_addr_s  = addr_q;
        acc_size_s  = size_q;
        acc_we_s    = we_q;
        acc_uns_s   = uns_q;
        acc_wdata_s = wdata_q;
        if (state_q == ST_IDLE) begin
            acc_addr_s  = req_addr;
            acc_size_s  = req_size;
            acc_we_s    = req_we;
            acc_uns_s   = req_unsigned;
            acc_wdata_s = req_wdata;
        end else begin
            acc_addr_s  = addr_q;
            acc_size_s  = size_q;
            acc_we_s    = we_q;
            acc_uns_s   = uns_q;
            acc_wdata_s = wdata_q;
        end
    end

    assign acc_idx_s = acc_addr_s[BA_W-1:2];

    // Pre-write word read; out-of-range indices never commit, so read zero.
    always_comb begin
        raw_s = 32'h0000_0000;
        if ({1'b0, acc_idx_s} < DEPTH_L) begin
            raw_s = mem_q[acc_idx_s];
        end else begin
            raw_s = 32'h0000_0000;
        end
    end

    dm_lane_align u_align (
        .addr_i     (acc_addr_s[1:0]),
        .size_i     (acc_size_s),
        .unsigned_i (acc_uns_s),
        .wdata_i    (acc_wdata_s),
        .raw_i      (raw_s),
        .be_o       (be_s),
        .wdata_o    (wdata_lane_s),
        .rdata_o    (load_data_s)
    );

    // Next-state, request latching, commit strobe and response generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        size_d      = size_q;
        we_d        = we_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
        rsp_fault_d = 1'b0;
        commit_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    if (req_fault_s) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                    end else if (WAIT_EN) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d     = ST_RESP;
                        commit_s    = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = acc_we_s ? 32'h0000_0000 : load_data_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == {WAIT_W{1'b0}}) begin
                    state_d     = ST_RESP;
                    commit_s    = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = acc_we_s ? 32'h0000_0000 : load_data_s;
                end else begin
                    cnt_d = cnt_q - {{(WAIT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control, latched request and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {WAIT_W{1'b0}};
            addr_q      <= {BA_W{1'b0}};
            size_q      <= 2'b00;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            wdata_q     <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    // Byte-enabled store commit on the edge that enters RESP.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (commit_s && acc_we_s && be_s[k]) begin
                mem_q[acc_idx_s][8*k +: 8] <= wdata_lane_s[8*k +: 8];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: directed self-checking bench. Two instances: u_dut0 (WAIT=0)
// and u_dut3 (WAIT=3), sharing request fields but with separate valid/reset.
module tb_dm_lsu;

    logic        clk = 1'b0;
    logic        rst_n0, rst_n3;
    logic        rv0, rv3;
    logic        req_we;
    logic [13:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rdy0, rdy3, vld0, vld3, flt0, flt3;
    logic [31:0] rd0, rd3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dm_lsu #(.ADDR_W(12), .DEPTH(3072), .WAIT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n0), .req_valid(rv0), .req_ready(rdy0),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(vld0), .rsp_rdata(rd0), .rsp_fault(flt0)
    );

    dm_lsu #(.ADDR_W(12), .DEPTH(3072), .WAIT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n3), .req_valid(rv3), .req_ready(rdy3),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(vld3), .rsp_rdata(rd3), .rsp_fault(flt3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request on the selected instance; checks ready, latency, one-cycle
    // strobe, ready low during the response, rdata (under mask) and fault.
    task automatic run(input int sel, input string tag, input logic we,
                       input logic [13:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic [31:0] mask,
                       input logic exp_flt);
        int          lat;
        logic        seen;
        logic [31:0] got_rd;
        logic        got_flt;
        logic        got_rdy;
        @(negedge clk);
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        check_eq({tag, "/ready"}, {31'h0, (sel == 0) ? rdy0 : rdy3}, 32'h1);
        if (sel == 0) rv0 = 1'b1; else rv3 = 1'b1;
        @(posedge clk);
        #1;
        rv0          = 1'b0;
        rv3          = 1'b0;
        // Scramble inputs after accept: the latched request must be used.
        req_we       = ~we;
        req_addr     = ~addr;
        req_size     = ~size;
        req_unsigned = ~uns;
        req_wdata    = ~wdata;
        seen = 1'b0; lat = 0; got_rd = 32'h0; got_flt = 1'b0; got_rdy = 1'b1;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (((sel == 0) ? vld0 : vld3) === 1'b1) begin
                seen    = 1'b1;
                got_rd  = (sel == 0) ? rd0 : rd3;
                got_flt = (sel == 0) ? flt0 : flt3;
                got_rdy = (sel == 0) ? rdy0 : rdy3;
            end
        end
        check_eq({tag, "/latency"}, 32'(lat), (exp_flt || sel == 0) ? 32'd1 : 32'd4);
        check_eq({tag, "/rdata"}, got_rd & mask, exp_rd & mask);
        check_eq({tag, "/fault"}, {31'h0, got_flt}, {31'h0, exp_flt});
        check_eq({tag, "/rdy_in_resp"}, {31'h0, got_rdy}, 32'h0);
        @(negedge clk);
        check_eq({tag, "/strobe_1cyc"}, {31'h0, (sel == 0) ? vld0 : vld3}, 32'h0);
    endtask

    initial begin
        int rsp_cnt;
        int rsp_idx;
        int rdy_idx;
        logic [31:0] rsp_data;
        logic        seen;

        rst_n0 = 1'b0; rst_n3 = 1'b0; rv0 = 1'b0; rv3 = 1'b0;
        req_we = 1'b0; req_addr = 14'h0; req_size = 2'b00;
        req_unsigned = 1'b0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst/valid", {31'h0, vld0}, 32'h0);
        check_eq("rst/rdata", rd0, 32'h0);
        check_eq("rst/fault", {31'h0, flt0}, 32'h0);
        check_eq("rst/ready", {31'h0, rdy0}, 32'h1);
        rst_n0 = 1'b1; rst_n3 = 1'b1;

        // WAIT=0: word round trip, byte lanes, extension.
        run(0, "st_w",   1'b1, 14'h010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        32'hFFFFFFFF, 1'b0);
        run(0, "ld_w",   1'b0, 14'h010, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 1'b0);
        run(0, "st_b",   1'b1, 14'h013, 2'b00, 1'b0, 32'hAAAAAA80, 32'h0,        32'hFFFFFFFF, 1'b0);
        run(0, "ld_bs",  1'b0, 14'h013, 2'b00, 1'b0, 32'h0,        32'hFFFFFF80, 32'hFFFFFFFF, 1'b0);
        run(0, "ld_bu",  1'b0, 14'h013, 2'b00, 1'b1, 32'h0,        32'h00000080, 32'hFFFFFFFF, 1'b0);
        run(0, "ld_w2",  1'b0, 14'h010, 2'b10, 1'b1, 32'h0,        32'h80ADBEEF, 32'hFFFFFFFF, 1'b0);
        run(0, "ld_hs",  1'b0, 14'h012, 2'b01, 1'b0, 32'h0,        32'hFFFF80AD, 32'hFFFFFFFF, 1'b0);
        run(0, "ld_hu",  1'b0, 14'h010, 2'b01, 1'b1, 32'h0,        32'h0000BEEF, 32'hFFFFFFFF, 1'b0);
        run(0, "ld_hs0", 1'b0, 14'h010, 2'b01, 1'b0, 32'h0,        32'hFFFFBEEF, 32'hFFFFFFFF, 1'b0);
        run(0, "ld_b1",  1'b0, 14'h011, 2'b00, 1'b0, 32'h0,        32'hFFFFFFBE, 32'hFFFFFFFF, 1'b0);
        run(0, "ld_b0u", 1'b0, 14'h010, 2'b00, 1'b1, 32'h0,        32'h000000EF, 32'hFFFFFFFF, 1'b0);

        // Half store touches only the upper lanes of word 0x020.
        run(0, "st_h",   1'b1, 14'h022, 2'b01, 1'b0, 32'hFFFF1234, 32'h0,        32'hFFFFFFFF, 1'b0);
        run(0, "ld_w20", 1'b0, 14'h020, 2'b10, 1'b0, 32'h0,        32'h12340000, 32'hFFFF0000, 1'b0);
        run(0, "ld_h22", 1'b0, 14'h022, 2'b01, 1'b0, 32'h0,        32'h00001234, 32'hFFFFFFFF, 1'b0);

        // Faults, and the target word must survive a faulted store.
        run(0, "st_w4",  1'b1, 14'h004, 2'b10, 1'b0, 32'h11223344, 32'h0,        32'hFFFFFFFF, 1'b0);
        run(0, "f_half", 1'b0, 14'h001, 2'b01, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b1);
        run(0, "f_word", 1'b1, 14'h006, 2'b10, 1'b0, 32'h99999999, 32'h0,        32'hFFFFFFFF, 1'b1);
        run(0, "f_size", 1'b0, 14'h004, 2'b11, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b1);
        run(0, "f_rng",  1'b0, 14'h3000, 2'b10, 1'b0, 32'h0,       32'h0,        32'hFFFFFFFF, 1'b1);
        run(0, "f_rngb", 1'b1, 14'h3001, 2'b00, 1'b0, 32'h000000FF, 32'h0,       32'hFFFFFFFF, 1'b1);
        run(0, "ld_w4",  1'b0, 14'h004, 2'b10, 1'b0, 32'h0,        32'h11223344, 32'hFFFFFFFF, 1'b0);
        run(0, "st_top", 1'b1, 14'h2FFC, 2'b10, 1'b0, 32'hA5A55A5A, 32'h0,       32'hFFFFFFFF, 1'b0);
        run(0, "ld_top", 1'b0, 14'h2FFC, 2'b10, 1'b0, 32'h0,       32'hA5A55A5A, 32'hFFFFFFFF, 1'b0);

        // WAIT=3 round trip.
        run(3, "w3_st",  1'b1, 14'h040, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0,        32'hFFFFFFFF, 1'b0);
        run(3, "w3_ld",  1'b0, 14'h040, 2'b10, 1'b0, 32'h0,        32'hCAFEF00D, 32'hFFFFFFFF, 1'b0);
        run(3, "w3_flt", 1'b0, 14'h041, 2'b10, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b1);

        // WAIT=3 with req_valid held: response 4 edges after accept, next accept 5 after.
        @(negedge clk);
        req_we = 1'b0; req_addr = 14'h040; req_size = 2'b10; req_unsigned = 1'b0;
        check_eq("hold/ready0", {31'h0, rdy3}, 32'h1);
        rv3 = 1'b1;
        rsp_cnt = 0; rsp_idx = -1; rdy_idx = -1; rsp_data = 32'h0;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            if (vld3 === 1'b1) begin
                rsp_cnt++;
                if (rsp_idx < 0) begin
                    rsp_idx  = i;
                    rsp_data = rd3;
                end
            end
            if (rdy3 === 1'b1 && rdy_idx < 0) rdy_idx = i;
        end
        rv3 = 1'b0;
        check_eq("hold/rsp_cnt", 32'(rsp_cnt), 32'd1);
        check_eq("hold/rsp_idx", 32'(rsp_idx), 32'd4);
        check_eq("hold/rsp_data", rsp_data, 32'hCAFEF00D);
        check_eq("hold/next_acc", 32'(rdy_idx), 32'd5);
        repeat (5) @(negedge clk);

        // Reset during WAIT: the store never commits and no response appears.
        req_we = 1'b1; req_addr = 14'h040; req_size = 2'b10; req_wdata = 32'h55555555;
        rv3 = 1'b1;
        @(posedge clk);
        #1;
        rv3 = 1'b0;
        @(negedge clk);
        rst_n3 = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (vld3 !== 1'b0) seen = 1'b1;
        end
        rst_n3 = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (vld3 !== 1'b0) seen = 1'b1;
        end
        check_eq("rst_mid/no_rsp", {31'h0, seen}, 32'h0);
        check_eq("rst_mid/ready", {31'h0, rdy3}, 32'h1);
        run(3, "rst_mid/ld", 1'b0, 14'h040, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
